// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and a saturating bubble counter.
// Define FORWARD_UNIT_EN to build the EX-stage forwarding selects; otherwise forwardA/forwardB are tied to 00.
module id_ex_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [31:0]            id_pc,
    input  logic [31:0]            id_ReadData1,
    input  logic [31:0]            id_ReadData2,
    input  logic [31:0]            id_Extimm,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic [4:0]             id_rd,
    input  logic [9:0]             id_ctrl,
    input  logic                   flush,
    input  logic                   MEM_RegWrite,
    input  logic [4:0]             MEM_WriteReg,
    input  logic                   WB_RegWrite,
    input  logic [4:0]             WB_WriteReg,
    output logic                   stall,
    output logic                   EX_valid,
    output logic [31:0]            EX_pc,
    output logic [31:0]            EX_ReadData1,
    output logic [31:0]            EX_ReadData2,
    output logic [31:0]            EX_Extimm,
    output logic [4:0]             EX_rs,
    output logic [4:0]             EX_rt,
    output logic [4:0]             EX_rd,
    output logic [9:0]             EX_ctrl,
    output logic [1:0]             forwardA,
    output logic [1:0]             forwardB,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // id_ctrl = {RegDst,ALUSrc,MemRead,MemWrite,MemtoReg,RegWrite,ALUOp[3:0]}
    localparam int CTRL_MEMREAD = 7;

    logic                   valid_q, valid_d;
    logic [31:0]            pc_q, pc_d;
    logic [31:0]            rd1_q, rd1_d;
    logic [31:0]            rd2_q, rd2_d;
    logic [31:0]            imm_q, imm_d;
    logic [4:0]             rs_q, rs_d;
    logic [4:0]             rt_q, rt_d;
    logic [4:0]             rd_q, rd_d;
    logic [9:0]             ctrl_q, ctrl_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   load_in_ex;
    logic                   bubble;

    always_comb begin
        load_in_ex = valid_q & ctrl_q[CTRL_MEMREAD] & (rt_q != 5'd0);
        stall      = ~flush & id_valid & load_in_ex & ((rt_q == id_rs) | (rt_q == id_rt));
        bubble     = flush | stall;
    end

    always_comb begin
        valid_d = 1'b0;
        pc_d    = '0;
        rd1_d   = '0;
        rd2_d   = '0;
        imm_d   = '0;
        rs_d    = '0;
        rt_d    = '0;
        rd_d    = '0;
        ctrl_d  = '0;
        if (!bubble) begin
            valid_d = id_valid;
            pc_d    = id_pc;
            rd1_d   = id_ReadData1;
            rd2_d   = id_ReadData2;
            imm_d   = id_Extimm;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
            ctrl_d  = id_ctrl;
        end
        // Only hazard bubbles are counted; flush bubbles never raise stall.
        cnt_d = cnt_q;
        if (stall && (cnt_q != {STALL_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign EX_valid     = valid_q;
    assign EX_pc        = pc_q;
    assign EX_ReadData1 = rd1_q;
    assign EX_ReadData2 = rd2_q;
    assign EX_Extimm    = imm_q;
    assign EX_rs        = rs_q;
    assign EX_rt        = rt_q;
    assign EX_rd        = rd_q;
    assign EX_ctrl      = ctrl_q;
    assign stall_cnt    = cnt_q;

`ifdef FORWARD_UNIT_EN
    // MEM is the younger producer, so it wins over WB; $0 is hardwired and never forwarded.
    always_comb begin
        forwardA = 2'b00;
        forwardB = 2'b00;
        if (valid_q) begin
            if (MEM_RegWrite && (MEM_WriteReg != 5'd0) && (MEM_WriteReg == rs_q)) begin
                forwardA = 2'b10;
            end else if (WB_RegWrite && (WB_WriteReg != 5'd0) && (WB_WriteReg == rs_q)) begin
                forwardA = 2'b01;
            end
            if (MEM_RegWrite && (MEM_WriteReg != 5'd0) && (MEM_WriteReg == rt_q)) begin
                forwardB = 2'b10;
            end else if (WB_RegWrite && (WB_WriteReg != 5'd0) && (WB_WriteReg == rt_q)) begin
                forwardB = 2'b01;
            end
        end
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{MEM_RegWrite, MEM_WriteReg, WB_RegWrite, WB_WriteReg};
    assign forwardA = 2'b00;
    assign forwardB = 2'b00;
`endif

endmodule
